udp_tx_sched: RTL and testbench

- Two-channel transmit scheduler that shares the single UDP send path of the MAC between two FIFO-backed sources.
- Channel 0 is the video stream; channel 1 is the status/telemetry stream.
- Gates on ARP resolution and FIFO fill level, then issues one-cycle UDP send requests with round-robin fairness.
- Holds the data-mux select stable for the whole packet and enforces an inter-packet gap and a send timeout.

---
 rtl/udp_tx_sched.sv | 150 +++++++++++++++
 tb/tb_udp_tx_sched.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx_sched.sv
// Two-channel UDP transmit scheduler: round-robin grant of the MAC send path
// gated on ARP resolution and FIFO fill, with inter-packet gap and send timeout.
module udp_tx_sched #(
  parameter int unsigned GAP_CYCLES     = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 125000000,
  parameter int unsigned CNT_W          = 13
) (
  input  logic             gmii_tx_clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             arp_ready,
  input  logic [CNT_W-1:0] ch0_count,
  input  logic [15:0]      ch0_len,
  input  logic [CNT_W-1:0] ch1_count,
  input  logic [15:0]      ch1_len,
  input  logic             mac_send_end,
  output logic             udp_tx_req,
  output logic [15:0]      udp_send_data_length,
  output logic             ch_sel,
  output logic             busy,
  output logic [15:0]      ch0_sent,
  output logic [15:0]      ch1_sent,
  output logic             timeout_err
);

  localparam int unsigned ToW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [ToW-1:0]  ToLast  = ToW'(TIMEOUT_CYCLES - 1);
  localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StReq, StSend, StGap} state_e;

  state_e state_q, state_d;

  logic            req_q, req_d;
  logic [15:0]     len_q, len_d;
  logic            sel_q, sel_d;
  logic            last_q, last_d;
  logic            busy_q, busy_d;
  logic [15:0]     sent0_q, sent0_d;
  logic [15:0]     sent1_q, sent1_d;
  logic            to_err_q, to_err_d;
  logic [ToW-1:0]  to_cnt_q, to_cnt_d;
  logic [GapW-1:0] gap_cnt_q, gap_cnt_d;

  // FIFO holds 16-bit words, so compare twice the word count against the byte length.
  logic [16:0] ch0_bytes, ch1_bytes;
  logic        ch0_elig, ch1_elig;
  logic        start, grant, to_hit, gap_hit;

  assign ch0_bytes = 17'({ch0_count, 1'b0});
  assign ch1_bytes = 17'({ch1_count, 1'b0});
  assign ch0_elig  = (ch0_len != 16'd0) && (ch0_bytes >= {1'b0, ch0_len});
  assign ch1_elig  = (ch1_len != 16'd0) && (ch1_bytes >= {1'b0, ch1_len});
  assign start     = enable && arp_ready && (ch0_elig || ch1_elig);
  assign grant     = (ch0_elig && ch1_elig) ? ~last_q : ch1_elig;
  assign to_hit    = (to_cnt_q == ToLast);
  assign gap_hit   = (gap_cnt_q == GapLast);

  always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StReq;
      StReq:   state_d = StSend;
      StSend:  if (mac_send_end || to_hit) state_d = StGap;
      StGap:   if (gap_hit) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_d     = 1'b0;
    len_d     = len_q;
    sel_d     = sel_q;
    last_d    = last_q;
    sent0_d   = sent0_q;
    sent1_d   = sent1_q;
    to_err_d  = 1'b0;
    to_cnt_d  = to_cnt_q;
    gap_cnt_d = gap_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          req_d  = 1'b1;
          sel_d  = grant;
          last_d = grant;
          len_d  = grant ? ch1_len : ch0_len;
        end
      end
      StReq: to_cnt_d = '0;
      StSend: begin
        to_cnt_d  = to_cnt_q + 1'b1;
        gap_cnt_d = '0;
        // A frame end on the timeout cycle wins: count it, no error.
        if (mac_send_end) begin
          if (sel_q) sent1_d = sent1_q + 16'd1;
          else       sent0_d = sent0_q + 16'd1;
        end else if (to_hit) begin
          to_err_d = 1'b1;
        end
      end
      StGap:   gap_cnt_d = gap_cnt_q + 1'b1;
      default: ;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q     <= 1'b0;
      len_q     <= 16'd0;
      sel_q     <= 1'b0;
      last_q    <= 1'b1;
      busy_q    <= 1'b0;
      sent0_q   <= 16'd0;
      sent1_q   <= 16'd0;
      to_err_q  <= 1'b0;
      to_cnt_q  <= '0;
      gap_cnt_q <= '0;
    end else begin
      req_q     <= req_d;
      len_q     <= len_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
      sent0_q   <= sent0_d;
      sent1_q   <= sent1_d;
      to_err_q  <= to_err_d;
      to_cnt_q  <= to_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  assign udp_tx_req           = req_q;
  assign udp_send_data_length = len_q;
  assign ch_sel               = sel_q;
  assign busy                 = busy_q;
  assign ch0_sent             = sent0_q;
  assign ch1_sent             = sent1_q;
  assign timeout_err          = to_err_q;

endmodule

// File: tb/tb_udp_tx_sched.sv
// Directed plus randomized bench for udp_tx_sched against a packet-level model.
module tb_udp_tx_sched;

  localparam int unsigned Gap = 4;
  localparam int unsigned To  = 100;
  localparam int unsigned Cw  = 13;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          arp_ready;
  logic [Cw-1:0] ch0_count;
  logic [15:0]   ch0_len;
  logic [Cw-1:0] ch1_count;
  logic [15:0]   ch1_len;
  logic          mac_send_end;
  logic          udp_tx_req;
  logic [15:0]   udp_send_data_length;
  logic          ch_sel;
  logic          busy;
  logic [15:0]   ch0_sent;
  logic [15:0]   ch1_sent;
  logic          timeout_err;

  udp_tx_sched #(
    .GAP_CYCLES    (Gap),
    .TIMEOUT_CYCLES(To),
    .CNT_W         (Cw)
  ) dut (
    .gmii_tx_clk         (clk),
    .rst_n               (rst_n),
    .enable              (enable),
    .arp_ready           (arp_ready),
    .ch0_count           (ch0_count),
    .ch0_len             (ch0_len),
    .ch1_count           (ch1_count),
    .ch1_len             (ch1_len),
    .mac_send_end        (mac_send_end),
    .udp_tx_req          (udp_tx_req),
    .udp_send_data_length(udp_send_data_length),
    .ch_sel              (ch_sel),
    .busy                (busy),
    .ch0_sent            (ch0_sent),
    .ch1_sent            (ch1_sent),
    .timeout_err         (timeout_err)
  );

  always #4 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Packet-level model state
  int m_last  = 1;
  int m_sent0 = 0;
  int m_sent1 = 0;
  int m_sel   = 0;
  int m_len   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_elig(input int len, input int cnt);
    return (len != 0) && (2 * cnt >= len);
  endfunction

  function automatic int m_grant();
    bit e0 = m_elig(int'(ch0_len), int'(ch0_count));
    bit e1 = m_elig(int'(ch1_len), int'(ch1_count));
    if (e0 && e1) return 1 - m_last;
    return e1 ? 1 : 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   32'(udp_tx_req), 0);
    check({tag, "_len"},   32'(udp_send_data_length), 0);
    check({tag, "_sel"},   32'(ch_sel), 0);
    check({tag, "_busy"},  32'(busy), 0);
    check({tag, "_sent0"}, 32'(ch0_sent), 0);
    check({tag, "_sent1"}, 32'(ch1_sent), 0);
    check({tag, "_toerr"}, 32'(timeout_err), 0);
  endtask

  task automatic expect_no_req(input string tag, input int n);
    bit seen = 1'b0;
    repeat (n) begin
      tick();
      if (udp_tx_req) seen = 1'b1;
    end
    check(tag, 32'(seen), 0);
  endtask

  // Called at an IDLE cycle with eligible inputs; ends in SEND cycle 1.
  task automatic start_pkt(input string tag, input int exp_lat);
    int g   = m_grant();
    int len = (g == 1) ? int'(ch1_len) : int'(ch0_len);
    int lat = 0;
    do begin
      tick();
      lat++;
    end while (!udp_tx_req && lat < 20);
    check({tag, "_req"}, 32'(udp_tx_req), 1);
    if (exp_lat > 0) check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_sel"}, 32'(ch_sel), 32'(g));
    check({tag, "_len"}, 32'(udp_send_data_length), 32'(len));
    check({tag, "_busy"}, 32'(busy), 1);
    m_last = g;
    m_sel  = g;
    m_len  = len;
    tick();
    check({tag, "_req1cyc"}, 32'(udp_tx_req), 0);
  endtask

  // From SEND cycle 1: frame end after 'extra' more cycles, then the gap.
  task automatic finish_pkt(input string tag, input int extra);
    repeat (extra) tick();
    mac_send_end = 1'b1;
    tick();
    mac_send_end = 1'b0;
    if (m_sel == 1) m_sent1 = (m_sent1 + 1) % 65536;
    else            m_sent0 = (m_sent0 + 1) % 65536;
    check({tag, "_sent0"}, 32'(ch0_sent), 32'(m_sent0));
    check({tag, "_sent1"}, 32'(ch1_sent), 32'(m_sent1));
    check({tag, "_noerr"}, 32'(timeout_err), 0);
    check({tag, "_hold"}, {15'd0, ch_sel, udp_send_data_length}, 32'((m_sel << 16) | m_len));
    repeat (Gap - 1) tick();
    check({tag, "_gapbusy"}, 32'(busy), 1);
    tick();
    check({tag, "_idle"}, 32'(busy), 0);
  endtask

  task automatic set_inputs(input int l0, input int c0, input int l1, input int c1);
    ch0_len   = 16'(l0);
    ch0_count = Cw'(c0);
    ch1_len   = 16'(l1);
    ch1_count = Cw'(c1);
  endtask

  initial begin
    int k;
    rst_n        = 1'b0;
    enable       = 1'b0;
    arp_ready    = 1'b0;
    mac_send_end = 1'b0;
    set_inputs(0, 0, 0, 0);
    #1;
    check_reset_outputs("rst");
    tick();
    tick();
    rst_n = 1'b1;
    enable    = 1'b1;
    arp_ready = 1'b1;

    // Basic ch0 packet with a 50-cycle send
    set_inputs(1240, 620, 0, 0);
    start_pkt("t1", 1);
    finish_pkt("t1", 49);

    // Fill-level threshold, even and odd lengths
    set_inputs(1240, 619, 0, 0);
    expect_no_req("t2_619", 20);
    ch0_count = Cw'(620);
    start_pkt("t2_620", 1);
    finish_pkt("t2_620", 3);
    set_inputs(1241, 620, 0, 0);
    expect_no_req("t2_odd620", 20);
    ch0_count = Cw'(621);
    start_pkt("t2_odd621", 1);
    finish_pkt("t2_odd621", 3);

    // Both eligible: alternate, ch0 last granted so ch1 is next
    set_inputs(1240, 620, 64, 32);
    for (int i = 0; i < 4; i++) begin
      start_pkt("t3", 1);
      check("t3_alt", 32'(ch_sel), 32'((i % 2 == 0) ? 1 : 0));
      finish_pkt("t3", 5);
    end

    // ARP not resolved blocks grants
    arp_ready = 1'b0;
    expect_no_req("t4_arp", 1000);
    arp_ready = 1'b1;
    start_pkt("t4_en", 1);
    enable = 1'b0;
    finish_pkt("t4_en", 10);
    expect_no_req("t4_noen", 50);
    enable = 1'b1;

    // Timeout with no frame end
    start_pkt("t5", 1);
    k = 0;
    do begin
      tick();
      k++;
    end while (!timeout_err && k < 200);
    check("t5_tocycle", 32'(k), 32'(To));
    check("t5_sent0", 32'(ch0_sent), 32'(m_sent0));
    check("t5_sent1", 32'(ch1_sent), 32'(m_sent1));
    tick();
    check("t5_pulse", 32'(timeout_err), 0);
    repeat (Gap - 2) tick();
    check("t5_gapbusy", 32'(busy), 1);
    tick();
    check("t5_idle", 32'(busy), 0);
    // Re-grant, frame end on the timeout cycle itself
    start_pkt("t5_regrant", 1);
    finish_pkt("t5_endonto", To - 1);

    // Randomized traffic against the model
    for (int i = 0; i < 14; i++) begin
      set_inputs($urandom_range(0, 2000), $urandom_range(0, 1200),
                 $urandom_range(0, 2000), $urandom_range(0, 1200));
      if (!m_elig(int'(ch0_len), int'(ch0_count)) && !m_elig(int'(ch1_len), int'(ch1_count))) begin
        expect_no_req("rnd_none", 10);
      end else begin
        start_pkt("rnd", 1);
        ch0_len = 16'($urandom);
        ch1_len = 16'($urandom);
        finish_pkt("rnd", $urandom_range(0, 60));
      end
    end

    // Asynchronous reset mid-SEND with ch1 in flight
    set_inputs(0, 0, 64, 32);
    start_pkt("t6", 1);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_rst");
    m_last  = 1;
    m_sent0 = 0;
    m_sent1 = 0;
    set_inputs(1240, 620, 64, 32);
    tick();
    rst_n = 1'b1;
    start_pkt("t6_after", 0);
    check("t6_first_ch0", 32'(ch_sel), 0);
    finish_pkt("t6_after", 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
